// File: rtl/terrain_pkg.sv
// Shared constants, FSM state encoding and per-slot position arithmetic for the
// terrain scroll controller.
package terrain_pkg;

  localparam logic [15:0] SCREEN_W     = 16'd1280;
  localparam logic [15:0] SCREEN_H     = 16'd720;
  localparam logic [15:0] RST_X_BASE   = 16'd144;
  localparam logic [15:0] RST_X_STRIDE = 16'd256;
  localparam logic [15:0] RST_Y        = 16'd390;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pos_t;

  // Power-on position of slot k: slots staggered 256 px apart on one row.
  function automatic pos_t reset_pos(input int unsigned k);
    pos_t p;
    p.x = RST_X_BASE + 16'(k) * RST_X_STRIDE;
    p.y = RST_Y;
    return p;
  endfunction

  // One frame of motion; a slot that has left the screen respawns instead of moving.
  function automatic pos_t step_pos(input pos_t        cur,
                                    input logic [15:0] step,
                                    input logic [15:0] spawn_x,
                                    input logic [15:0] spawn_y);
    pos_t nxt;
    if (cur.x >= SCREEN_W || cur.y >= SCREEN_H) begin
      nxt.x = spawn_x;
      nxt.y = spawn_y;
    end else begin
      nxt.x = cur.x - step;
      nxt.y = cur.y + step;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the raw vertical sync into the pixel clock domain and emits a
// single-cycle tick on each synchronised rising edge.
module vsync_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_v_sync,
  output logic o_tick
);

  logic sync_q1;
  logic sync_q2;
  logic sync_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_q1   <= i_v_sync;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  assign o_tick = sync_q2 & ~sync_prev;

endmodule

// File: rtl/terrain_scroll_ctrl.sv
// Per-frame terrain slot sequencer: updates one slot per cycle into shadow
// registers, then commits all slots at once. Define TERRAIN_SPEED_EN for i_speed.
module terrain_scroll_ctrl
  import terrain_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int SPAWN_X = 180,
  parameter int SPAWN_Y = 360
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_v_sync,
  input  logic                   i_active,
  input  logic                   i_state_check,
`ifdef TERRAIN_SPEED_EN
  input  logic [1:0]             i_speed,
`endif
  output logic [16*NUM_SEG-1:0]  o_seg_x,
  output logic [16*NUM_SEG-1:0]  o_seg_y,
  output logic                   o_frame_done,
  output logic                   o_busy,
  output logic [15:0]            o_frame_cnt,
  output logic                   o_overrun
);

  localparam int          IDX_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);
  localparam logic [15:0] SPAWN_X16 = 16'(SPAWN_X);
  localparam logic [15:0] SPAWN_Y16 = 16'(SPAWN_Y);

  logic             tick;
  logic [15:0]      step;
  state_t           state;
  logic [IDX_W-1:0] idx;
  pos_t             shadow    [NUM_SEG];
  pos_t             committed [NUM_SEG];

  vsync_edge_sync u_vsync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_v_sync (i_v_sync),
    .o_tick   (tick)
  );

`ifdef TERRAIN_SPEED_EN
  assign step = 16'(i_speed) + 16'd1;
`else
  assign step = 16'd1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
      o_overrun    <= 1'b0;
      // NOTE: the slot arrays are reset explicitly because their contents are
      // architecturally visible positions, not scratch storage.
      for (int k = 0; k < NUM_SEG; k++) begin
        shadow[k]    <= reset_pos(k);
        committed[k] <= reset_pos(k);
      end
    end else begin
      o_frame_done <= 1'b0;

      // A tick is only accepted from IDLE; anything arriving mid-frame is lost.
      if (tick && o_busy) begin
        o_overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (tick && i_active && !i_state_check) begin
            state  <= ST_UPDATE;
            idx    <= '0;
            o_busy <= 1'b1;
          end
        end

        ST_UPDATE: begin
          shadow[idx] <= step_pos(shadow[idx], step, SPAWN_X16, SPAWN_Y16);
          if (idx == LAST_IDX) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_COMMIT: begin
          for (int k = 0; k < NUM_SEG; k++) begin
            committed[k] <= shadow[k];
          end
          o_frame_done <= 1'b1;
          o_frame_cnt  <= o_frame_cnt + 16'd1;
          o_busy       <= 1'b0;
          state        <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_pack
    assign o_seg_x[16*k +: 16] = committed[k].x;
    assign o_seg_y[16*k +: 16] = committed[k].y;
  end

endmodule

// File: tb/tb_terrain_scroll_ctrl.sv
// Self-checking bench for terrain_scroll_ctrl: vector table, randomized frames
// against a position model, and hand-written overrun / reset corner cases.
module tb_terrain_scroll_ctrl;

  localparam int NUM_SEG = 4;
  localparam int SPAWN_X = 180;
  localparam int SPAWN_Y = 360;
`ifdef TERRAIN_SPEED_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif
  // Edges from raising v_sync to seeing o_frame_done: two synchroniser flops,
  // one cycle for the edge tick to be taken, then NUM_SEG+1 for update/commit.
  localparam int LATENCY = 2 + 1 + NUM_SEG + 1;
  localparam int WINDOW  = 16;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_v_sync;
  logic                  i_active;
  logic                  i_state_check;
`ifdef TERRAIN_SPEED_EN
  logic [1:0]            i_speed;
`endif
  logic [16*NUM_SEG-1:0] o_seg_x;
  logic [16*NUM_SEG-1:0] o_seg_y;
  logic                  o_frame_done;
  logic                  o_busy;
  logic [15:0]           o_frame_cnt;
  logic                  o_overrun;

  terrain_scroll_ctrl #(
    .NUM_SEG (NUM_SEG),
    .SPAWN_X (SPAWN_X),
    .SPAWN_Y (SPAWN_Y)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_v_sync      (i_v_sync),
    .i_active      (i_active),
    .i_state_check (i_state_check),
`ifdef TERRAIN_SPEED_EN
    .i_speed       (i_speed),
`endif
    .o_seg_x       (o_seg_x),
    .o_seg_y       (o_seg_y),
    .o_frame_done  (o_frame_done),
    .o_busy        (o_busy),
    .o_frame_cnt   (o_frame_cnt),
    .o_overrun     (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integer positions, frame counter and overrun flag.
  int m_x [NUM_SEG];
  int m_y [NUM_SEG];
  int m_cnt;
  int m_over;

  typedef struct {
    bit    active;
    bit    frozen;
    bit    expect_frame;
    string name;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_SEG; k++) begin
      m_x[k] = 144 + 256 * k;
      m_y[k] = 390;
    end
    m_cnt  = 0;
    m_over = 0;
  endtask

  task automatic model_frame();
    for (int k = 0; k < NUM_SEG; k++) begin
      if (m_x[k] >= 1280 || m_y[k] >= 720) begin
        m_x[k] = SPAWN_X;
        m_y[k] = SPAWN_Y;
      end else begin
        m_x[k] = (m_x[k] - STEP) & 32'hFFFF;
        m_y[k] = (m_y[k] + STEP) & 32'hFFFF;
      end
    end
    m_cnt = (m_cnt + 1) & 32'hFFFF;
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < NUM_SEG; k++) begin
      check($sformatf("%s x[%0d]", tag, k), int'(o_seg_x[16*k +: 16]), m_x[k]);
      check($sformatf("%s y[%0d]", tag, k), int'(o_seg_y[16*k +: 16]), m_y[k]);
    end
    check({tag, " frame_cnt"}, int'(o_frame_cnt), m_cnt);
    check({tag, " overrun"}, int'(o_overrun), m_over);
  endtask

  // One v_sync pulse, then a bounded observation window.
  task automatic run_frame(input bit active, input bit frozen,
                           output int dones, output int busy_seen, output int lat);
    i_active      = active;
    i_state_check = frozen;
    dones         = 0;
    busy_seen     = 0;
    lat           = -1;
    @(negedge i_clk);
    i_v_sync = 1'b1;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge i_clk);
      if (c == 2) i_v_sync = 1'b0;
      if (o_frame_done) begin
        dones++;
        if (lat < 0) lat = c;
      end
      if (o_busy) busy_seen = 1;
    end
  endtask

  task automatic do_frame(input bit active, input bit frozen, input bit expect_frame,
                          input string tag);
    int dones, busy_seen, lat;
    run_frame(active, frozen, dones, busy_seen, lat);
    if (expect_frame) begin
      model_frame();
      check({tag, " latency"}, lat, LATENCY);
    end else begin
      check({tag, " busy stayed low"}, busy_seen, 0);
    end
    check({tag, " done pulses"}, dones, int'(expect_frame));
    check_outputs(tag);
  endtask

  initial begin
    int px, py, dones, busy_seen, lat;
    bit reloaded, wrapped;

    vecs[0] = '{1'b1, 1'b0, 1'b1, "vec run"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, "vec inactive"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, "vec frozen"};
    vecs[3] = '{1'b0, 1'b1, 1'b0, "vec inactive frozen"};
    vecs[4] = '{1'b1, 1'b0, 1'b1, "vec run again"};
    vecs[5] = '{1'b1, 1'b1, 1'b0, "vec frozen again"};
    vecs[6] = '{1'b1, 1'b0, 1'b1, "vec run third"};
    vecs[7] = '{1'b0, 1'b0, 1'b0, "vec idle"};

    i_rst_n       = 1'b0;
    i_v_sync      = 1'b0;
    i_active      = 1'b0;
    i_state_check = 1'b0;
`ifdef TERRAIN_SPEED_EN
    i_speed       = 2'd3;
`endif
    model_reset();
    repeat (3) @(negedge i_clk);
    check("reset busy", int'(o_busy), 0);
    check("reset frame_done", int'(o_frame_done), 0);
    check_outputs("in reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("reset slot0 x", int'(o_seg_x[15:0]), 144);
    check("reset slot3 x", int'(o_seg_x[63:48]), 912);
    check_outputs("after reset");

    // First frame from reset, with explicit slot0 values.
    do_frame(1'b1, 1'b0, 1'b1, "first frame");
    check("first slot0 x", int'(o_seg_x[15:0]), 144 - STEP);
    check("first slot0 y", int'(o_seg_y[15:0]), 390 + STEP);
    check("first frame_cnt", int'(o_frame_cnt), 1);

    foreach (vecs[i]) begin
      do_frame(vecs[i].active, vecs[i].frozen, vecs[i].expect_frame, vecs[i].name);
    end

    for (int i = 0; i < 30; i++) begin
      bit a, f;
      a = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      do_frame(a, f, a && !f, $sformatf("rand %0d", i));
    end

    // Run until slot 3 crosses the bottom edge and respawns; slot 0 wraps x first.
    reloaded = 0;
    wrapped  = 0;
    for (int i = 0; i < 400 && !reloaded; i++) begin
      px = m_x[3];
      py = m_y[3];
      do_frame(1'b1, 1'b0, 1'b1, "long run");
      if (!wrapped && m_x[0] == 65535) begin
        wrapped = 1;
        check("slot0 x wrapped to 65535", int'(o_seg_x[15:0]), 65535);
      end
      if (px >= 1280 || py >= 720) begin
        reloaded = 1;
`ifndef TERRAIN_SPEED_EN
        check("slot3 y before reload", py, 720);
`endif
        check("slot3 reload x", int'(o_seg_x[63:48]), SPAWN_X);
        check("slot3 reload y", int'(o_seg_y[63:48]), SPAWN_Y);
      end
    end
    check("slot3 reload reached", int'(reloaded), 1);
    check("slot0 wrap reached", int'(wrapped), 1);

    // Second rising edge two cycles after the first tick: dropped, sticky overrun.
    i_active      = 1'b1;
    i_state_check = 1'b0;
    @(negedge i_clk);
    i_v_sync = 1'b1;
    @(negedge i_clk);
    i_v_sync = 1'b0;
    @(negedge i_clk);
    i_v_sync = 1'b1;
    dones = 0;
    for (int c = 1; c <= 2 * WINDOW; c++) begin
      @(negedge i_clk);
      if (c == 3) i_v_sync = 1'b0;
      if (o_frame_done) dones++;
    end
    model_frame();
    m_over = 1;
    check("overrun done pulses", dones, 1);
    check_outputs("overrun");
    do_frame(1'b1, 1'b0, 1'b1, "after overrun");

    // Reset in the middle of UPDATE: partial work discarded, no commit.
    @(negedge i_clk);
    i_v_sync = 1'b1;
    dones = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge i_clk);
      if (c == 2) i_v_sync = 1'b0;
      if (c == 4) check("busy before mid reset", int'(o_busy), 1);
      if (o_frame_done) dones++;
    end
    i_rst_n = 1'b0;
    model_reset();
    @(negedge i_clk);
    check("mid reset busy", int'(o_busy), 0);
    i_rst_n = 1'b1;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge i_clk);
      if (o_frame_done) dones++;
    end
    check("mid reset done pulses", dones, 0);
    check_outputs("mid reset");
    do_frame(1'b1, 1'b0, 1'b1, "after mid reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/terrain_scroll_ctrl.md
TERRAIN_SCROLL_CTRL -- requirements
Module: terrain_scroll_ctrl

Interface
REQ-001 SHALL have parameter NUM_SEG, default 4, meaning number of terrain segment slots sequenced (1..8).
REQ-002 SHALL have parameter SPAWN_X, default 180, meaning x reload value on wrap.
REQ-003 SHALL have parameter SPAWN_Y, default 360, meaning y reload value on wrap.
REQ-004 SHALL have port i_clk  input  1  system pixel clock; only clock.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_v_sync  input  1  raw vertical sync, asynchronous to i_clk.
REQ-007 SHALL have port i_active  input  1  scroll enable switch.
REQ-008 SHALL have port i_state_check  input  1  game state; 1 = frozen.
REQ-009 SHALL have port o_seg_x  output  16*NUM_SEG  committed x per slot, slot k at bits [16k+15:16k].
REQ-010 SHALL have port o_seg_y  output  16*NUM_SEG  committed y per slot, same packing.
REQ-011 SHALL have port o_frame_done  output  1  one-cycle pulse on commit.
REQ-012 SHALL have port o_busy  output  1  high while not IDLE.
REQ-013 SHALL have port o_frame_cnt  output  16  count of committed frames.
REQ-014 SHALL have port o_overrun  output  1  sticky flag: tick arrived while busy.

Function
REQ-015 SHALL synchronise i_v_sync with two flops and produce a one-cycle tick on its synchronised rising edge.
REQ-016 SHALL implement FSM IDLE -> UPDATE -> COMMIT -> IDLE.
REQ-017 IDLE SHALL go to UPDATE on tick only when i_active=1 and i_state_check=0; otherwise tick is ignored (no count, no flag).
REQ-018 UPDATE SHALL process one slot per cycle, index 0..NUM_SEG-1, into shadow registers, then go to COMMIT.
REQ-019 Per slot, using pre-update values: if x>=1280 or y>=720, load (SPAWN_X, SPAWN_Y); else x<=x-1, y<=y+1, modulo 2^16.
REQ-020 x=0 SHALL decrement to 65535 and reload on the following frame.
REQ-021 COMMIT SHALL copy all shadow registers to o_seg_x/o_seg_y in one cycle, pulse o_frame_done, increment o_frame_cnt (wrapping 65535->0).
REQ-022 Committed outputs SHALL change only in COMMIT; latency tick -> o_frame_done = NUM_SEG+1 cycles.
REQ-023 A tick arriving while o_busy=1 SHALL be dropped and set o_overrun until reset.
REQ-024 i_active/i_state_check changes during UPDATE SHALL NOT abort the frame.

Reset
REQ-025 On i_rst_n=0: FSM IDLE, sync flops 0, o_frame_done 0, o_busy 0, o_frame_cnt 0, o_overrun 0.
REQ-026 On reset, slot k shadow and committed values SHALL be x=144+256*k, y=390.
REQ-027 Reset mid-UPDATE SHALL discard partial work; no o_frame_done.

Configuration
REQ-028 With TERRAIN_SPEED_EN defined: SHALL add input i_speed (2 bits); step = i_speed+1 for both x decrement and y increment.
REQ-029 Without TERRAIN_SPEED_EN: no i_speed port; step fixed at 1.

Structure
REQ-030 Package terrain_pkg SHALL hold SCREEN_W=1280, SCREEN_H=720, reset-position constants and the FSM state enum.
REQ-031 Sub-module vsync_edge_sync SHALL contain the two-flop synchroniser and edge detector.

Verification
REQ-032 Reset, NUM_SEG=4 -> o_seg_x = 144,400,656,912; o_seg_y = 390 all; o_frame_cnt=0.
REQ-033 i_active=1, i_state_check=0, one v_sync pulse -> o_frame_done 5 cycles after tick; slot0 = (143,391); o_frame_cnt=1.
REQ-034 Slot3 x=912, y=390, after 330 frames -> y reaches 720, next frame reloads (180,360).
REQ-035 i_state_check=1 with v_sync pulses -> positions and o_frame_cnt unchanged, o_busy stays 0.
REQ-036 Second v_sync rising edge forced 2 cycles after first tick -> o_overrun=1, only one o_frame_done.
REQ-037 TERRAIN_SPEED_EN, i_speed=3, one frame from reset -> slot0 = (140,394).
